// File: rtl/jk_pkg.sv
// jk_pkg: shared definitions for the JK counter register.
//   jk_mode_t  2-bit operating mode
//   MODE_JK    per-bit JK bank
//   MODE_UP    synchronous up counter
//   MODE_DN    synchronous down counter
//   MODE_LD    parallel load
package jk_pkg;

  typedef logic [1:0] jk_mode_t;

  localparam jk_mode_t MODE_JK = 2'b00;
  localparam jk_mode_t MODE_UP = 2'b01;
  localparam jk_mode_t MODE_DN = 2'b10;
  localparam jk_mode_t MODE_LD = 2'b11;

endpackage

// File: rtl/jk_counter_reg_if.sv
// jk_counter_reg_if: control/data bundle for jk_counter_reg.
//   en        cycle enable
//   mode      jk_mode_t operating mode
//   J, K      per-bit JK inputs (JK mode only)
//   d         parallel load data (load mode only)
//   clr_wrap  clears the sticky wrap flag
//   Q         register state
//   tc        terminal count (combinational)
//   wrap      sticky wrap flag
// master drives the controls, slave (the counter) drives Q/tc/wrap.
interface jk_counter_reg_if #(
  parameter int WIDTH = 8
);

  logic                 en;
  jk_pkg::jk_mode_t     mode;
  logic [WIDTH-1:0]     J;
  logic [WIDTH-1:0]     K;
  logic [WIDTH-1:0]     d;
  logic                 clr_wrap;
  logic [WIDTH-1:0]     Q;
  logic                 tc;
  logic                 wrap;

  modport master (
    output en, mode, J, K, d, clr_wrap,
    input  Q, tc, wrap
  );

  modport slave (
    input  en, mode, J, K, d, clr_wrap,
    output Q, tc, wrap
  );

endinterface

// File: rtl/jk_cell.sv
// jk_cell: one JK flip-flop with synchronous reset, enable and load.
//   clk      rising-edge clock
//   rst      synchronous active-high reset (q <= rst_val)
//   rst_val  reset value for this bit
//   en       cycle enable; 0 holds q
//   j, k     JK inputs: 00 hold, 10 set, 01 reset, 11 toggle
//   ld       load d instead of applying JK
//   d        load data
//   q        flop state
// Priority: rst > en > ld > JK.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic ld,
  input  logic d,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= rst_val;
    end else if (en) begin
      if (ld) begin
        r_q <= d;
      end else begin
        case ({j, k})
          2'b10:   r_q <= 1'b1;
          2'b01:   r_q <= 1'b0;
          2'b11:   r_q <= ~r_q;
          default: r_q <= r_q;
        endcase
      end
    end
  end

  assign q = r_q;

endmodule

// File: rtl/jk_counter_reg.sv
// jk_counter_reg: WIDTH-bit bank of JK cells usable as a JK register,
// an up/down counter built from JK toggle chains, or a loadable register.
//   clk   rising-edge clock
//   rst   synchronous active-high reset (Q <= RST_VAL, wrap <= 0)
//   bus   jk_counter_reg_if slave: en, mode, J, K, d, clr_wrap in;
//         Q, tc, wrap out
// tc is combinational: all-ones while counting up, zero while counting
// down, otherwise 0. wrap is sticky and set whenever an enabled count
// step rolls over; a simultaneous clr_wrap loses to the set.
module jk_counter_reg
  import jk_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  jk_counter_reg_if.slave   bus
);

  jk_mode_t           w_mode;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_j;
  logic [WIDTH-1:0]   w_k;
  logic               w_ld;
  logic               w_tc;
  // w_ones_pre[i] = bits 0..i-1 all 1; w_zeros_pre[i] = bits 0..i-1 all 0.
  // Index 0 is the empty prefix, so bit 0 always toggles when counting.
  logic [WIDTH:0]     w_ones_pre;
  logic [WIDTH:0]     w_zeros_pre;
  logic               r_wrap;

  assign w_mode         = bus.mode;
  assign w_ones_pre[0]  = 1'b1;
  assign w_zeros_pre[0] = 1'b1;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chain
    assign w_ones_pre[gi+1]  = w_ones_pre[gi]  &  w_q[gi];
    assign w_zeros_pre[gi+1] = w_zeros_pre[gi] & ~w_q[gi];
  end

  // Only the JK mode routes the external J/K through, so undriven J/K
  // cannot disturb the counter or load paths.
  always_comb begin
    w_j  = '0;
    w_k  = '0;
    w_ld = 1'b0;
    case (w_mode)
      MODE_JK: begin
        w_j = bus.J;
        w_k = bus.K;
      end
      MODE_UP: begin
        w_j = w_ones_pre[WIDTH-1:0];
        w_k = w_ones_pre[WIDTH-1:0];
      end
      MODE_DN: begin
        w_j = w_zeros_pre[WIDTH-1:0];
        w_k = w_zeros_pre[WIDTH-1:0];
      end
      default: begin
        w_ld = 1'b1;
      end
    endcase
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    jk_cell u_cell (
      .clk     (clk),
      .rst     (rst),
      .rst_val (RST_VAL[gi]),
      .en      (bus.en),
      .j       (w_j[gi]),
      .k       (w_k[gi]),
      .ld      (w_ld),
      .d       (bus.d[gi]),
      .q       (w_q[gi])
    );
  end

  // Full prefix across all bits marks the last state before rollover.
  assign w_tc = ((w_mode == MODE_UP) && w_ones_pre[WIDTH]) ||
                ((w_mode == MODE_DN) && w_zeros_pre[WIDTH]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap <= 1'b0;
    end else if (bus.en && w_tc) begin
      r_wrap <= 1'b1;
    end else if (bus.clr_wrap) begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.Q    = w_q;
  assign bus.tc   = w_tc;
  assign bus.wrap = r_wrap;

endmodule

// File: tb/tb_jk_counter_reg.sv
// tb_jk_counter_reg: directed self-checking bench for jk_counter_reg
// (WIDTH=4). A second instance with RST_VAL=4'h3 covers mid-count reset.
module tb_jk_counter_reg;
  import jk_pkg::*;

  logic clk;
  logic rst;
  logic rst3;
  int   errors;
  int   checks;

  jk_counter_reg_if #(.WIDTH(4)) bus0 ();
  jk_counter_reg_if #(.WIDTH(4)) bus3 ();

  jk_counter_reg #(.WIDTH(4), .RST_VAL(4'h0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  jk_counter_reg #(.WIDTH(4), .RST_VAL(4'h3)) dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (bus3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  initial begin
    errors = 0;
    checks = 0;

    // 1. reset dominates a pending load
    rst  = 1'b1;
    rst3 = 1'b1;
    bus0.en = 1'b1; bus0.mode = MODE_LD; bus0.d = 4'hF;
    bus0.J = 4'h0;  bus0.K = 4'h0;       bus0.clr_wrap = 1'b0;
    bus3.en = 1'b1; bus3.mode = MODE_JK; bus3.d = 4'h0;
    bus3.J = 4'h0;  bus3.K = 4'h0;       bus3.clr_wrap = 1'b0;
    tick();
    tick();
    chk("rst_q",    bus0.Q,    4'h0);
    chk("rst_wrap", bus0.wrap, 1'b0);
    chk("rst_tc",   bus0.tc,   1'b0);
    chk("rst3_q",   bus3.Q,    4'h3);
    rst = 1'b0;

    // 2. JK bank: per bit toggle, set, reset, hold
    bus0.mode = MODE_LD; bus0.d = 4'h5;
    tick();
    chk("ld_5", bus0.Q, 4'h5);
    bus0.mode = MODE_JK; bus0.J = 4'b1100; bus0.K = 4'b1010;
    tick();
    chk("jk_1", bus0.Q, 4'b1101);
    chk("jk_tc", bus0.tc, 1'b0);
    bus0.J = 4'b0011; bus0.K = 4'b0110;
    tick();
    chk("jk_2", bus0.Q, 4'b1011);

    // 3. load E then count up through the wrap; J/K left undriven
    bus0.J = 'x; bus0.K = 'x;
    bus0.mode = MODE_LD; bus0.d = 4'hE;
    tick();
    chk("ld_e", bus0.Q, 4'hE);
    chk("ld_tc", bus0.tc, 1'b0);
    bus0.mode = MODE_UP;
    chk("up_tc_e", bus0.tc, 1'b0);
    tick();
    chk("up_f", bus0.Q, 4'hF);
    chk("up_tc_f", bus0.tc, 1'b1);
    chk("up_wrap_f", bus0.wrap, 1'b0);
    tick();
    chk("up_0", bus0.Q, 4'h0);
    chk("up_wrap_0", bus0.wrap, 1'b1);
    chk("up_tc_0", bus0.tc, 1'b0);
    tick();
    chk("up_1", bus0.Q, 4'h1);
    chk("up_wrap_1", bus0.wrap, 1'b1);

    // 4. count down from 1 through the underflow
    bus0.mode = MODE_DN;
    tick();
    chk("dn_0", bus0.Q, 4'h0);
    chk("dn_tc_0", bus0.tc, 1'b1);
    tick();
    chk("dn_f", bus0.Q, 4'hF);
    chk("dn_wrap", bus0.wrap, 1'b1);
    // load 0 while clearing: load does not set wrap
    bus0.mode = MODE_LD; bus0.d = 4'h0; bus0.clr_wrap = 1'b1;
    tick();
    chk("clr_ld_q", bus0.Q, 4'h0);
    chk("clr_ld_wrap", bus0.wrap, 1'b0);
    // clear and underflow on the same edge: set wins
    bus0.mode = MODE_DN;
    tick();
    chk("set_win_q", bus0.Q, 4'hF);
    chk("set_win_wrap", bus0.wrap, 1'b1);
    bus0.clr_wrap = 1'b0;

    // 5. enable gating while counting up
    bus0.mode = MODE_LD; bus0.d = 4'h5;
    tick();
    bus0.mode = MODE_UP;
    tick();
    chk("en1_6", bus0.Q, 4'h6);
    bus0.en = 1'b0;
    tick();
    chk("en0_6", bus0.Q, 4'h6);
    chk("en0_wrap", bus0.wrap, 1'b1);
    bus0.en = 1'b1;
    tick();
    chk("en1_7", bus0.Q, 4'h7);
    bus0.en = 1'b0; bus0.clr_wrap = 1'b1;
    tick();
    chk("en0_clr_wrap", bus0.wrap, 1'b0);
    chk("en0_clr_q", bus0.Q, 4'h7);
    bus0.clr_wrap = 1'b0;
    // disabled at terminal count: no step, no wrap
    bus0.en = 1'b1; bus0.mode = MODE_LD; bus0.d = 4'hF;
    tick();
    bus0.en = 1'b0; bus0.mode = MODE_UP;
    tick();
    chk("en0_tc_q", bus0.Q, 4'hF);
    chk("en0_tc_wrap", bus0.wrap, 1'b0);

    // 6. reset mid-count returns to RST_VAL=3, then resumes counting
    rst3 = 1'b0;
    bus3.mode = MODE_LD; bus3.d = 4'h9;
    tick();
    chk("r3_ld_9", bus3.Q, 4'h9);
    bus3.mode = MODE_UP; rst3 = 1'b1;
    tick();
    chk("r3_mid_rst", bus3.Q, 4'h3);
    chk("r3_wrap", bus3.wrap, 1'b0);
    rst3 = 1'b0;
    tick();
    chk("r3_up_4", bus3.Q, 4'h4);
    tick();
    chk("r3_up_5", bus3.Q, 4'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
